// File: rtl/mems_mics_sample_writer.sv
// Streams interleaved mic PCM beats into a circular dual-port RAM buffer.
// Optional frame-sync checking is enabled with MEMS_WRITER_FRAME_CHECK_EN.
module mems_mics_sample_writer #(
    parameter int ADDR_W = 10,
    parameter int NUM_CH = 8,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_sop,
    output logic [ADDR_W-1:0]     wr_address,
    output logic                  wr_chipselect,
    output logic                  wr_write,
    output logic [DATA_W/8-1:0]   wr_byteenable,
    output logic [DATA_W-1:0]     wr_writedata,
    output logic [ADDR_W-1:0]     wr_ptr,
    output logic [15:0]           frame_count,
    output logic                  irq_half,
    output logic                  irq_wrap,
    output logic [7:0]            frame_err_count
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [ADDR_W-1:0] HALF_ADDR = ADDR_W'((2**ADDR_W) / 2 - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);

    logic                accept;
    logic                do_write;
    logic [ADDR_W-1:0]   waddr;
    logic [ADDR_W-1:0]   ptr_q, ptr_n;
    logic [CH_W-1:0]     ch_q, ch_n;
    logic [15:0]         fc_q, fc_n;
    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;

    assign in_ready = enable & ~clear;
    assign accept   = in_valid & in_ready;

`ifdef MEMS_WRITER_FRAME_CHECK_EN
    localparam logic [ADDR_W-1:0] CH_MASK = ADDR_W'(NUM_CH - 1);
    logic [7:0] err_q, err_n;
    logic       sop_late;
    logic       sop_missing;

    assign sop_late    = in_sop & (ch_q != '0);
    assign sop_missing = ~in_sop & (ch_q == '0);
`else
    logic unused_sop;
    assign unused_sop = in_sop;
`endif

    always_comb begin
        do_write = accept;
        waddr    = ptr_q;
        ptr_n    = ptr_q;
        ch_n     = ch_q;
        fc_n     = fc_q;
`ifdef MEMS_WRITER_FRAME_CHECK_EN
        err_n    = err_q;
`endif
        if (clear) begin
            ptr_n = '0;
            ch_n  = '0;
            fc_n  = '0;
`ifdef MEMS_WRITER_FRAME_CHECK_EN
            err_n = '0;
`endif
        end else if (accept) begin
            ptr_n = ptr_q + 1'b1;
            if (ch_q == CH_LAST) begin
                ch_n = '0;
                fc_n = fc_q + 16'd1;
            end else begin
                ch_n = ch_q + 1'b1;
            end
`ifdef MEMS_WRITER_FRAME_CHECK_EN
            // Early sop: realign to the next frame slot, leaving a hole.
            if (sop_late) begin
                waddr = (ptr_q | CH_MASK) + 1'b1;
                ptr_n = waddr + 1'b1;
                ch_n  = CH_W'(1);
                fc_n  = fc_q;
            end else if (sop_missing) begin
                do_write = 1'b0;
                ptr_n    = ptr_q;
                ch_n     = ch_q;
                fc_n     = fc_q;
            end
            if ((sop_late || sop_missing) && err_q != 8'hFF)
                err_n = err_q + 8'd1;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q  <= '0;
            ch_q   <= '0;
            fc_q   <= '0;
            wr_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            ptr_q  <= ptr_n;
            ch_q   <= ch_n;
            fc_q   <= fc_n;
            wr_q   <= do_write;
            if (do_write) begin
                addr_q <= waddr;
                data_q <= in_data;
            end
        end
    end

`ifdef MEMS_WRITER_FRAME_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            err_q <= '0;
        else
            err_q <= err_n;
    end
    assign frame_err_count = err_q;
`else
    assign frame_err_count = '0;
`endif

    assign wr_chipselect = wr_q;
    assign wr_write      = wr_q;
    assign wr_byteenable = {(DATA_W/8){wr_q}};
    assign wr_address    = wr_q ? addr_q : '0;
    assign wr_writedata  = wr_q ? data_q : '0;
    assign wr_ptr        = ptr_q;
    assign frame_count   = fc_q;
    assign irq_half      = wr_q && (addr_q == HALF_ADDR);
    assign irq_wrap      = wr_q && (addr_q == LAST_ADDR);

endmodule

// File: tb/tb_mems_mics_sample_writer.sv
// Directed bench for mems_mics_sample_writer (default 1024 x 32, 8 channels).
module tb_mems_mics_sample_writer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_sop;
    logic [9:0]  wr_address;
    logic        wr_chipselect;
    logic        wr_write;
    logic [3:0]  wr_byteenable;
    logic [31:0] wr_writedata;
    logic [9:0]  wr_ptr;
    logic [15:0] frame_count;
    logic        irq_half;
    logic        irq_wrap;
    logic [7:0]  frame_err_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mems_mics_sample_writer dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sop(in_sop), .wr_address(wr_address),
        .wr_chipselect(wr_chipselect), .wr_write(wr_write),
        .wr_byteenable(wr_byteenable), .wr_writedata(wr_writedata),
        .wr_ptr(wr_ptr), .frame_count(frame_count), .irq_half(irq_half),
        .irq_wrap(irq_wrap), .frame_err_count(frame_err_count)
    );

    task automatic beat(input logic sop, input logic [31:0] d);
        in_valid = 1'b1;
        in_sop   = sop;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b0; clear = 1'b0;
        in_valid = 1'b0; in_sop = 1'b0; in_data = '0;
        idle(); idle();
        checks++;
        if ({wr_write, wr_chipselect, wr_byteenable, wr_address, wr_writedata,
             wr_ptr, frame_count, irq_half, irq_wrap, frame_err_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: wr_write=%b addr=%0d ptr=%0d fc=%0d err=%0d, required all 0",
                     wr_write, wr_address, wr_ptr, frame_count, frame_err_count);
        end
        reset_n = 1'b1;
        enable  = 1'b1;
        idle();
    endtask

    task automatic test_basic_stream();
        test_reset();
        for (int i = 0; i < 16; i++) begin
            beat(i % 8 == 0, 32'(i));
            checks++;
            if (wr_write !== 1'b1 || wr_chipselect !== 1'b1 || wr_byteenable !== 4'hF
                || wr_address !== 10'(i) || wr_writedata !== 32'(i)) begin
                errors++;
                $display("FAIL basic_write[%0d]: we=%b cs=%b be=%h addr=%0d data=%0d, required 1 1 f %0d %0d",
                         i, wr_write, wr_chipselect, wr_byteenable, wr_address, wr_writedata, i, i);
            end
        end
        idle();
        checks++;
        if (wr_write !== 1'b0 || wr_chipselect !== 1'b0 || wr_byteenable !== 4'h0) begin
            errors++;
            $display("FAIL basic_idle_strobes: we=%b cs=%b be=%h, required 0 0 0",
                     wr_write, wr_chipselect, wr_byteenable);
        end
        checks++;
        if (wr_ptr !== 10'd16 || frame_count !== 16'd2) begin
            errors++;
            $display("FAIL basic_counters: ptr=%0d fc=%0d, required 16 2", wr_ptr, frame_count);
        end
    endtask

    task automatic test_wrap_irq();
        test_reset();
        for (int i = 0; i < 1024; i++) begin
            beat(i % 8 == 0, 32'h1000 + 32'(i));
            checks++;
            if (irq_half !== (i == 511) || irq_wrap !== (i == 1023)
                || wr_address !== 10'(i)) begin
                errors++;
                $display("FAIL wrap_irq[%0d]: half=%b wrap=%b addr=%0d, required %b %b %0d",
                         i, irq_half, irq_wrap, wr_address, i == 511, i == 1023, i);
            end
        end
        idle();
        checks++;
        if (irq_wrap !== 1'b0 || irq_half !== 1'b0) begin
            errors++;
            $display("FAIL wrap_irq_pulse: half=%b wrap=%b, required 0 0", irq_half, irq_wrap);
        end
        checks++;
        if (wr_ptr !== 10'd0 || frame_count !== 16'd128) begin
            errors++;
            $display("FAIL wrap_counters: ptr=%0d fc=%0d, required 0 128", wr_ptr, frame_count);
        end
        beat(1'b1, 32'hBEEF);
        checks++;
        if (wr_address !== 10'd0 || wr_writedata !== 32'hBEEF) begin
            errors++;
            $display("FAIL wrap_rewrite: addr=%0d data=%h, required 0 beef", wr_address, wr_writedata);
        end
    endtask

    task automatic test_early_sop();
        test_reset();
        beat(1'b1, 32'd1);
        beat(1'b0, 32'd2);
        beat(1'b0, 32'd3);
        beat(1'b1, 32'hA5);
`ifdef MEMS_WRITER_FRAME_CHECK_EN
        checks++;
        if (wr_write !== 1'b1 || wr_address !== 10'd8 || wr_writedata !== 32'hA5
            || frame_err_count !== 8'd1) begin
            errors++;
            $display("FAIL early_sop_write: we=%b addr=%0d data=%h err=%0d, required 1 8 a5 1",
                     wr_write, wr_address, wr_writedata, frame_err_count);
        end
        idle();
        checks++;
        if (wr_ptr !== 10'd9 || frame_count !== 16'd0) begin
            errors++;
            $display("FAIL early_sop_ptr: ptr=%0d fc=%0d, required 9 0", wr_ptr, frame_count);
        end
        beat(1'b0, 32'hB6);
        checks++;
        if (wr_address !== 10'd9 || frame_err_count !== 8'd1) begin
            errors++;
            $display("FAIL early_sop_next: addr=%0d err=%0d, required 9 1", wr_address, frame_err_count);
        end
`else
        checks++;
        if (wr_address !== 10'd3 || wr_writedata !== 32'hA5 || frame_err_count !== 8'd0) begin
            errors++;
            $display("FAIL sop_ignored: addr=%0d data=%h err=%0d, required 3 a5 0",
                     wr_address, wr_writedata, frame_err_count);
        end
        idle();
        checks++;
        if (wr_ptr !== 10'd4) begin
            errors++;
            $display("FAIL sop_ignored_ptr: ptr=%0d, required 4", wr_ptr);
        end
`endif
    endtask

    task automatic test_missing_sop();
        test_reset();
        beat(1'b0, 32'h55);
`ifdef MEMS_WRITER_FRAME_CHECK_EN
        checks++;
        if (wr_write !== 1'b0 || frame_err_count !== 8'd1 || wr_ptr !== 10'd0) begin
            errors++;
            $display("FAIL missing_sop: we=%b err=%0d ptr=%0d, required 0 1 0",
                     wr_write, frame_err_count, wr_ptr);
        end
        for (int i = 0; i < 300; i++) beat(1'b0, 32'(i));
        idle();
        checks++;
        if (frame_err_count !== 8'd255 || wr_ptr !== 10'd0 || wr_write !== 1'b0) begin
            errors++;
            $display("FAIL err_saturate: err=%0d ptr=%0d we=%b, required 255 0 0",
                     frame_err_count, wr_ptr, wr_write);
        end
`else
        checks++;
        if (wr_write !== 1'b1 || wr_address !== 10'd0 || frame_err_count !== 8'd0) begin
            errors++;
            $display("FAIL no_check_write: we=%b addr=%0d err=%0d, required 1 0 0",
                     wr_write, wr_address, frame_err_count);
        end
        idle();
        checks++;
        if (wr_ptr !== 10'd1) begin
            errors++;
            $display("FAIL no_check_ptr: ptr=%0d, required 1", wr_ptr);
        end
`endif
    endtask

    task automatic test_clear();
        test_reset();
        for (int i = 0; i < 9; i++) beat(i % 8 == 0, 32'h20 + 32'(i));
        clear    = 1'b1;
        in_valid = 1'b1;
        in_sop   = 1'b0;
        in_data  = 32'hDEAD;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_ready: in_ready=%b, required 0", in_ready);
        end
        checks++;
        if (wr_write !== 1'b1 || wr_address !== 10'd8 || wr_writedata !== 32'h28) begin
            errors++;
            $display("FAIL clear_pending: we=%b addr=%0d data=%h, required 1 8 28",
                     wr_write, wr_address, wr_writedata);
        end
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (wr_write !== 1'b0 || wr_ptr !== 10'd0 || frame_count !== 16'd0
            || frame_err_count !== 8'd0) begin
            errors++;
            $display("FAIL clear_state: we=%b ptr=%0d fc=%0d err=%0d, required 0 0 0 0",
                     wr_write, wr_ptr, frame_count, frame_err_count);
        end
    endtask

    task automatic test_enable_and_async_reset();
        test_reset();
        beat(1'b1, 32'h1);
        enable   = 1'b0;
        in_valid = 1'b1;
        in_sop   = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL disabled_ready: in_ready=%b, required 0", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (wr_write !== 1'b0 || wr_ptr !== 10'd1) begin
            errors++;
            $display("FAIL disabled_write: we=%b ptr=%0d, required 0 1", wr_write, wr_ptr);
        end
        enable = 1'b1;
        for (int i = 1; i < 11; i++) beat(i % 8 == 0, 32'h70 + 32'(i));
        in_valid = 1'b1;
        in_data  = 32'h99;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({wr_write, wr_chipselect, wr_byteenable, wr_address, wr_writedata,
             wr_ptr, frame_count, irq_half, irq_wrap, frame_err_count} !== '0) begin
            errors++;
            $display("FAIL async_reset: we=%b addr=%0d data=%h ptr=%0d fc=%0d, required all 0",
                     wr_write, wr_address, wr_writedata, wr_ptr, frame_count);
        end
        in_valid = 1'b0;
        idle();
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic_stream();
        test_wrap_irq();
        test_early_sop();
        test_missing_sop();
        test_clear();
        test_enable_and_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
